// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : Y86-64 writeback stage. Holds the fifteen program registers,
//               the sticky status/halt machine and the cycle/retire counters.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int          CNT_W    = 32,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_status,
    input  logic [63:0]      W_valE,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       W_destE,
    input  logic [3:0]       W_destM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    output logic [1:0]       prog_status,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [3:0]       c_REG_NONE = 4'hF;
    localparam logic [3:0]       c_ICODE_NOP = 4'h1;
    localparam logic [1:0]       c_STAT_AOK = 2'b00;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       status_q, status_d;
    logic [63:0]      regs_q [0:14];
    logic [63:0]      regs_d [0:14];
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             w_commit;

    assign w_commit = (state_q == ST_RUN) && (W_status == c_STAT_AOK);

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        regs_d    = regs_q;
        cycle_d   = cycle_q;
        retired_d = retired_q;

        if ((state_q == ST_RUN) && (W_status != c_STAT_AOK)) begin
            state_d  = ST_HALT;
            status_d = W_status;
        end

        if (w_commit) begin
            if (cycle_q != c_CNT_MAX) begin
                cycle_d = cycle_q + 1'b1;
            end
            if ((W_icode != c_ICODE_NOP) && (retired_q != c_CNT_MAX)) begin
                retired_d = retired_q + 1'b1;
            end
            // valM is applied last so it wins when both ports name one register
            if (W_destE != c_REG_NONE) begin
                regs_d[W_destE] = W_valE;
            end
            if (W_destM != c_REG_NONE) begin
                regs_d[W_destM] = W_valM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            status_q  <= c_STAT_AOK;
            cycle_q   <= '0;
            retired_q <= '0;
            for (int i = 0; i < 15; i++) begin
                regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
            end
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            regs_q    <= regs_d;
        end
    end

    assign d_rvalA       = (d_srcA == c_REG_NONE) ? 64'h0 : regs_q[d_srcA];
    assign d_rvalB       = (d_srcB == c_REG_NONE) ? 64'h0 : regs_q[d_srcB];
    assign prog_status   = status_q;
    assign halted        = (state_q == ST_HALT);
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_regfile
// Description : Randomised bench for writeback_regfile against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    localparam logic [63:0] RSP = 64'h200;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  W_icode;
    logic [1:0]  W_status;
    logic [63:0] W_valE, W_valM;
    logic [3:0]  W_destE, W_destM;
    logic [3:0]  d_srcA, d_srcB;
    logic [63:0] d_rvalA, d_rvalB;
    logic [1:0]  prog_status;
    logic        halted;
    logic [31:0] cycle_count, retired_count;

    logic [63:0] s_rvalA, s_rvalB;
    logic [1:0]  s_status;
    logic        s_halted;
    logic [3:0]  s_cycle, s_retired;

    always #5 clk = ~clk;

    writeback_regfile #(.CNT_W(32), .RSP_INIT(RSP)) u_dut (
        .clk(clk), .rst(rst), .W_icode(W_icode), .W_status(W_status),
        .W_valE(W_valE), .W_valM(W_valM), .W_destE(W_destE), .W_destM(W_destM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
        .prog_status(prog_status), .halted(halted),
        .cycle_count(cycle_count), .retired_count(retired_count)
    );

    // Narrow-counter instance shares the stimulus; only its counters are compared.
    writeback_regfile #(.CNT_W(4), .RSP_INIT(64'h0)) u_dut4 (
        .clk(clk), .rst(rst), .W_icode(W_icode), .W_status(W_status),
        .W_valE(W_valE), .W_valM(W_valM), .W_destE(W_destE), .W_destM(W_destM),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(s_rvalA), .d_rvalB(s_rvalB),
        .prog_status(s_status), .halted(s_halted),
        .cycle_count(s_cycle), .retired_count(s_retired)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: architectural state with unbounded counters, saturated at compare time.
    logic [63:0] m_regs [0:14];
    logic        m_halted;
    logic [1:0]  m_status;
    longint      m_cycle, m_retired;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) m_regs[i] <= (i == 4) ? RSP : 64'h0;
            m_halted  <= 1'b0;
            m_status  <= 2'b00;
            m_cycle   <= 0;
            m_retired <= 0;
        end else if (!m_halted) begin
            if (W_status != 2'b00) begin
                m_halted <= 1'b1;
                m_status <= W_status;
            end else begin
                m_cycle <= m_cycle + 1;
                if (W_icode != 4'h1) m_retired <= m_retired + 1;
                if (W_destE != 4'hF) m_regs[W_destE] <= W_valE;
                if (W_destM != 4'hF) m_regs[W_destM] <= W_valM;
            end
        end
    end

    function automatic logic [63:0] m_read(input logic [3:0] src);
        return (src == 4'hF) ? 64'h0 : m_regs[src];
    endfunction

    function automatic logic [63:0] sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) <<< w) - 1;
        return (v > mx) ? 64'(mx) : 64'(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("rvalA", d_rvalA, m_read(d_srcA));
            chk("rvalB", d_rvalB, m_read(d_srcB));
            chk("prog_status", {62'b0, prog_status}, {62'b0, m_status});
            chk("halted", {63'b0, halted}, {63'b0, m_halted});
            chk("cycle_count", {32'b0, cycle_count}, sat(m_cycle, 32));
            chk("retired_count", {32'b0, retired_count}, sat(m_retired, 32));
            chk("cycle_count_w4", {60'b0, s_cycle}, sat(m_cycle, 4));
            chk("retired_count_w4", {60'b0, s_retired}, sat(m_retired, 4));
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [1:0] st,
                         input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        W_icode = ic; W_status = st;
        W_destE = de; W_valE = ve;
        W_destM = dm; W_valM = vm;
    endtask

    task automatic idle;
        drive(4'h1, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);
    endtask

    logic [63:0] saved_r2;
    logic [31:0] saved_cyc;

    initial begin
        rst = 1'b1; d_srcA = 4'h0; d_srcB = 4'h0;
        drive(4'h5, 2'b01, 4'h2, 64'h1234, 4'h3, 64'h5678);
        tick;
        chk_en = 1'b1;
        // Hold reset while sweeping every register through both read ports
        for (int i = 0; i < 15; i++) begin
            d_srcA = 4'(i); d_srcB = 4'(14 - i);
            #1;
            chk("reset_read", d_rvalA, (i == 4) ? 64'h200 : 64'h0);
            tick;
        end
        chk("reset_halted", {63'b0, halted}, 64'h0);
        chk("reset_status", {62'b0, prog_status}, 64'h0);
        chk("reset_cycle", {32'b0, cycle_count}, 64'h0);
        chk("reset_retired", {32'b0, retired_count}, 64'h0);
        rst = 1'b0;

        drive(4'h5, 2'b00, 4'h0, 64'h5, 4'h3, 64'hDEAD);
        d_srcA = 4'h0; d_srcB = 4'h3;
        tick;
        idle;
        chk("dual_A", d_rvalA, 64'h5);
        chk("dual_B", d_rvalB, 64'hDEAD);
        chk("dual_retired", {32'b0, retired_count}, 64'h1);

        drive(4'h2, 2'b00, 4'h4, 64'h1F8, 4'h4, 64'h77);
        d_srcA = 4'h4; d_srcB = 4'hF;
        #1;
        chk("same_cycle_old", d_rvalA, 64'h200);
        chk("srcF_zero", d_rvalB, 64'h0);
        tick;
        idle;
        chk("same_dest_M_wins", d_rvalA, 64'h77);

        for (int n = 0; n < 200; n++) begin
            drive(4'($urandom_range(0, 11)), 2'b00,
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), {$urandom, $urandom});
            d_srcA = 4'($urandom_range(0, 15));
            d_srcB = 4'($urandom_range(0, 15));
            tick;
        end

        d_srcA = 4'h2;
        saved_r2 = m_regs[2];
        drive(4'h0, 2'b01, 4'h2, 64'h9, 4'hF, 64'h0);
        saved_cyc = cycle_count;
        tick;
        chk("halt_flag", {63'b0, halted}, 64'h1);
        chk("halt_status", {62'b0, prog_status}, 64'h1);
        for (int n = 0; n < 6; n++) begin
            drive(4'h3, (n == 3) ? 2'b10 : 2'b00, 4'h2, 64'h100 + 64'(n), 4'h2, 64'h200 + 64'(n));
            tick;
            chk("halt_reg2_frozen", d_rvalA, saved_r2);
        end
        chk("halt_status_sticky", {62'b0, prog_status}, 64'h1);
        chk("halt_cycle_frozen", {32'b0, cycle_count}, {32'b0, saved_cyc});

        rst = 1'b1; tick; rst = 1'b0;
        drive(4'h6, 2'b10, 4'h1, 64'hBAD, 4'hF, 64'h0);
        tick;
        idle;
        chk("adr_status", {62'b0, prog_status}, 64'h2);
        chk("adr_halted", {63'b0, halted}, 64'h1);
        rst = 1'b1;
        drive(4'h6, 2'b00, 4'h5, 64'hFFFF, 4'hF, 64'h0);
        tick;
        rst = 1'b0;
        chk("recover_halted", {63'b0, halted}, 64'h0);
        chk("recover_cycle", {32'b0, cycle_count}, 64'h0);
        chk("recover_retired", {32'b0, retired_count}, 64'h0);
        d_srcA = 4'h5;
        chk("recover_rst_discards", d_rvalA, 64'h0);
        drive(4'h6, 2'b00, 4'h5, 64'hABC, 4'hF, 64'h0);
        tick;
        chk("recover_write", d_rvalA, 64'hABC);

        rst = 1'b1; tick; rst = 1'b0;
        idle;
        for (int n = 0; n < 10; n++) tick;
        chk("nop_retired", {32'b0, retired_count}, 64'h0);
        chk("nop_cycle", {32'b0, cycle_count}, 64'd10);
        for (int n = 0; n < 10; n++) tick;
        chk("sat_cycle_w4", {60'b0, s_cycle}, 64'hF);
        chk("cycle_20", {32'b0, cycle_count}, 64'd20);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 29) == 0);
            drive(4'($urandom_range(0, 11)),
                  ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), {$urandom, $urandom});
            d_srcA = 4'($urandom_range(0, 15));
            d_srcB = 4'($urandom_range(0, 15));
            tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
